// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source and its monitor.
// period_valid is a one-cycle strobe with no backpressure: the consumer captures period while it is high.
interface div_clk_monitor_if #(
  parameter int CW = 11
);
  logic          clk_div_in;
  logic          clear_fault;
  logic          tick;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          fault;
  logic [1:0]    state_dbg;

  modport master (
    output clk_div_in, clear_fault,
    input  tick, period, period_valid, locked, fault, state_dbg
  );

  modport slave (
    input  clk_div_in, clear_fault,
    output tick, period, period_valid, locked, fault, state_dbg
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Synchronises a slow divided clock, emits a tick per rising edge, measures its
// period in clk100MHz cycles and tracks lock/fault against the expected period.
module div_clk_monitor #(
  parameter int EXPECTED_PERIOD = 1000,
  parameter int TOLERANCE       = 2,
  parameter int LOCK_COUNT      = 4
) (
  input  logic             clk100MHz,
  input  logic             rst,
  div_clk_monitor_if.slave bus
);
  localparam int TIMEOUT = 2 * EXPECTED_PERIOD;
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam int GW      = $clog2(LOCK_COUNT + 1);
  localparam int PER_LO  = (EXPECTED_PERIOD > TOLERANCE) ? EXPECTED_PERIOD - TOLERANCE : 0;
  localparam int PER_HI  = EXPECTED_PERIOD + TOLERANCE;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   MEAS_ONE = (CW+1)'(1);
  localparam logic [CW:0]   MEAS_LO  = (CW+1)'(PER_LO);
  localparam logic [CW:0]   MEAS_HI  = (CW+1)'(PER_HI);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [GW-1:0] GOOD_LCK = GW'(LOCK_COUNT);

  logic          s1_q, s2_q, s3_q;
  logic          rise;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [1:0]    state_q, state_d;
  logic          tick_q;
  logic [CW-1:0] period_q, period_d;
  logic          pv_q, pv_d;
  logic          locked_q, fault_q;
  logic [CW:0]   period_meas;
  logic          in_range;
  logic          timeout_hit;

  // s1/s2 form the synchroniser; s3 is the history bit for edge detection.
  assign rise        = s2_q & ~s3_q;
  assign period_meas = {1'b0, cnt_q} + MEAS_ONE;
  assign in_range    = (period_meas >= MEAS_LO) && (period_meas <= MEAS_HI);
  assign timeout_hit = (cnt_q == CNT_TMO) && !rise;
  assign good_inc    = good_q + GOOD_ONE;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: begin
        // The first edge only establishes a reference; nothing is measured.
        cnt_d = '0;
        if (rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = period_meas[CW-1:0];
          if (in_range) begin
            good_d = good_inc;
            if (good_inc == GOOD_LCK) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = period_meas[CW-1:0];
          if (!in_range) begin
            state_d = FAULT;
          end
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        // Clearing wins over a coincident edge, which is dropped unmeasured.
        if (bus.clear_fault) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise) begin
          pv_d     = 1'b1;
          period_d = period_meas[CW-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      good_q   <= '0;
      state_q  <= IDLE;
      tick_q   <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      s1_q     <= bus.clk_div_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      state_q  <= state_d;
      tick_q   <= rise;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= (state_d == LOCKED);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign bus.tick         = tick_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.fault        = fault_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor with EXPECTED_PERIOD=100, TOLERANCE=2, LOCK_COUNT=4.
module tb_div_clk_monitor;
  localparam int EXP = 100;
  localparam int TOL = 2;
  localparam int LCK = 4;
  localparam int CW  = $clog2(2 * EXP + 1);
  localparam int W   = CW + 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk100MHz = 1'b0;
  logic rst       = 1'b1;
  always #5 clk100MHz = ~clk100MHz;

  div_clk_monitor_if #(.CW(CW)) bus();

  div_clk_monitor #(
    .EXPECTED_PERIOD(EXP),
    .TOLERANCE      (TOL),
    .LOCK_COUNT     (LCK)
  ) dut (
    .clk100MHz(clk100MHz),
    .rst      (rst),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk100MHz) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int last_tick_cyc = 0;
  int tick_gap = 0;
  int pv_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare();
    logic [W-1:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_unexpected_pv observed period=%0d expected no period_valid", bus.period);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_lock_fault_period", {bus.locked, bus.fault, bus.period}, e);
    end
  endtask

  always @(negedge clk100MHz) begin
    if (bus.tick === 1'b1) begin
      tick_count    <= tick_count + 1;
      tick_gap      <= cyc - last_tick_cyc;
      last_tick_cyc <= cyc;
    end
    if (bus.period_valid === 1'b1) begin
      pv_count <= pv_count + 1;
      sb_compare();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic outputs_zero(input string tag);
    check({tag, "_flags"}, {bus.tick, bus.period_valid, bus.locked, bus.fault, bus.state_dbg}, 0);
    check({tag, "_period"}, bus.period, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clk_div_in = 1'b0;
    bus.clear_fault = 1'b0;
    @(posedge clk100MHz); #1;
    rst = 1'b0;
    outputs_zero("reset");
  endtask

  // One divided-clock period of p cycles, high for hi cycles. If exp_pv, the
  // rising edge at its start is expected to report {exp_lk, exp_ft, exp_per}.
  task automatic pulse(input int p, input int hi, input bit exp_pv, input int exp_per,
                       input bit exp_lk, input bit exp_ft, input int clr_idx, input int rst_idx);
    if (exp_pv) exp_q.push_back({exp_lk, exp_ft, exp_per[CW-1:0]});
    for (int i = 0; i < p; i++) begin
      if (rst_idx >= 0 && i == rst_idx + 1) outputs_zero("rst_mid");
      bus.clk_div_in  = (i < hi);
      bus.clear_fault = (i == clr_idx);
      rst             = (i == rst_idx);
      @(posedge clk100MHz); #1;
    end
    bus.clear_fault = 1'b0;
    rst = 1'b0;
  endtask

  task automatic sq(input int p);
    pulse(p, p / 2, 1'b0, 0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic sq_e(input int p, input int per, input bit lk, input bit ft);
    pulse(p, p / 2, 1'b1, per, lk, ft, -1, -1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, pv0;
    bus.clk_div_in = 1'b0;
    bus.clear_fault = 1'b0;
    do_reset();
    check("reset_state", bus.state_dbg, ST_IDLE);

    // Square wave of period 100; clear_fault mid-acquire must be ignored.
    t0 = tick_count;
    sq(100);
    sq_e(100, 100, 1'b0, 1'b0);
    pulse(100, 50, 1'b1, 100, 1'b0, 1'b0, 20, -1);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);
    check("sq_tick_count", tick_count - t0, 7);
    check("sq_tick_gap", tick_gap, 100);
    check("sq_locked", {bus.locked, bus.fault}, 2'b10);

    // Tolerance edges: 102 and 98 count, 103 restarts acquisition.
    do_reset();
    sq(102);
    sq_e(98, 102, 1'b0, 1'b0);
    sq_e(103, 98, 1'b0, 1'b0);
    sq_e(100, 103, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);
    check("tol_state", bus.state_dbg, ST_LOCKED);

    // Input stuck low while locked: fault exactly 200 cycles after the last tick.
    while (cyc < last_tick_cyc + 199) @(negedge clk100MHz);
    check("tmo_before", {bus.locked, bus.fault}, 2'b10);
    @(negedge clk100MHz);
    check("tmo_after", {bus.locked, bus.fault}, 2'b01);
    check("tmo_state", bus.state_dbg, ST_FAULT);
    @(posedge clk100MHz); #1;
    bus.clear_fault = 1'b1;
    @(posedge clk100MHz); #1;
    bus.clear_fault = 1'b0;
    check("clr_flags", {bus.locked, bus.fault}, 2'b00);
    check("clr_state", bus.state_dbg, ST_IDLE);
    pv0 = pv_count;
    sq(100);
    sq_e(100, 100, 1'b0, 1'b0);
    check("clr_two_rises_one_pv", pv_count - pv0, 1);

    // Lock, then a short period of 90: fault is sticky through good periods.
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(90, 100, 1'b1, 1'b0);
    sq_e(100, 90, 1'b0, 1'b1);
    sq_e(100, 100, 1'b0, 1'b1);
    sq_e(100, 100, 1'b0, 1'b1);
    check("short_state", bus.state_dbg, ST_FAULT);

    // clear_fault in the same cycle as rise: edge dropped, back to IDLE.
    pv0 = pv_count;
    t0 = tick_count;
    pulse(100, 50, 1'b0, 0, 1'b0, 1'b0, 2, -1);
    check("coinc_no_pv", pv_count - pv0, 0);
    check("coinc_tick", tick_count - t0, 1);
    check("coinc_state", bus.state_dbg, ST_IDLE);
    check("coinc_fault", bus.fault, 1'b0);
    sq(100);
    check("coinc_acquire", bus.state_dbg, ST_ACQUIRE);
    check("coinc_acq_no_pv", pv_count - pv0, 0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);

    // One-cycle reset mid-period while locked, then reacquire.
    pulse(100, 50, 1'b1, 100, 1'b1, 1'b0, -1, 70);
    check("rst_state", bus.state_dbg, ST_IDLE);
    t0 = tick_count;
    sq(100);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b0, 1'b0);
    sq_e(100, 100, 1'b1, 1'b0);
    check("reacq_ticks", tick_count - t0, 5);
    check("reacq_locked", bus.locked, 1'b1);

    // One-cycle-wide input pulses still give exactly one tick each.
    do_reset();
    t0 = tick_count;
    pulse(100, 1, 1'b0, 0, 1'b0, 1'b0, -1, -1);
    check("narrow_tick", tick_count - t0, 1);
    check("narrow_state", bus.state_dbg, ST_ACQUIRE);
    pulse(100, 1, 1'b1, 100, 1'b0, 1'b0, -1, -1);
    check("narrow_tick2", tick_count - t0, 2);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Receiving end of a clk_divider output. Samples the slow divided clock in the clk100MHz domain and synchronises it.
- Produces a single-cycle tick enable on each rising edge, measures the period in clk100MHz cycles, and reports lock or fault against the expected period.
- Sits between the clock dividers and the stopwatch logic/display, which consume tick as a clock enable instead of the raw divided clock.

Parameters:
- EXPECTED_PERIOD, 1000: nominal divided-clock period in clk100MHz cycles; must be >= 8.
- TOLERANCE, 2: allowed absolute deviation of a measured period, in cycles.
- LOCK_COUNT, 4: consecutive in-range periods required to lock; must be >= 1.
- Derived: TIMEOUT = 2*EXPECTED_PERIOD; CW = clog2(TIMEOUT+1).

Ports:
- clk100MHz  input  1  system clock, 100 MHz.
- rst  input  1  reset, synchronous, active-high.
- clk_div_in  input  1  divided clock from clk_divider; asynchronous to this block's sampling.
- clear_fault  input  1  one-cycle request to leave FAULT.
- tick  output  1  one-cycle pulse per rising edge of clk_div_in.
- period  output  CW  last measured period, in cycles.
- period_valid  output  1  one-cycle pulse when period is updated.
- locked  output  1  high only in LOCKED.
- fault  output  1  sticky, high only in FAULT.

Behaviour:
- Interface: one clock, clk100MHz. Reset rst is synchronous and active-high.
- Reset: on any clk100MHz edge with rst=1, all registers clear on that edge: s1, s2, s3, cnt, good_cnt, tick, period, period_valid, locked, fault; state=IDLE. An edge in flight is discarded.
- Synchroniser: s1<=clk_div_in, s2<=s1, s3<=s2. rise = s2 & ~s3 (combinational).
- tick: registered rise. It is high for exactly one cycle, the cycle after the 3rd edge that samples clk_div_in high. A 1-cycle-wide input pulse still produces one tick.
- cnt counts cycles since the last rise, in all states except IDLE:
  - on rise: cnt<=0;
  - otherwise: cnt<=cnt+1, saturating at TIMEOUT.
- Measurement: on rise with state != IDLE, period<=cnt+1 and period_valid<=1, registered together with tick. period holds between updates.
- In-range: |period_meas - EXPECTED_PERIOD| <= TOLERANCE, using unsigned compare with no wrap.
- timeout_hit = (cnt == TIMEOUT-1) and no rise.
- FSM transitions, all evaluated on the same edge that registers tick:
  - IDLE: on rise -> ACQUIRE, cnt<=0, good_cnt<=0, no period_valid. This first edge has no reference.
  - ACQUIRE, rise in range: good_cnt+1. If the new value equals LOCK_COUNT -> LOCKED.
  - ACQUIRE, rise out of range: good_cnt<=0, stay in ACQUIRE.
  - ACQUIRE, timeout_hit: -> IDLE.
  - LOCKED, rise in range: stay.
  - LOCKED, rise out of range or timeout_hit: -> FAULT.
  - FAULT: tick and period_valid keep operating. On clear_fault -> IDLE with cnt<=0. A rise in the same cycle as clear_fault is discarded and produces no period_valid.
- clear_fault outside FAULT has no effect.
- locked=(state==LOCKED) and fault=(state==FAULT), both registered. On a bad period in LOCKED, locked falls and fault rises in the same cycle that period_valid is high.
- Latency: clk_div_in rising -> tick, period_valid, and state outputs = 3 edges.

Test Plan (EXPECTED_PERIOD=100, TOLERANCE=2, LOCK_COUNT=4):
- Square wave, period 100, after reset:
  - ticks are 100 cycles apart;
  - period_valid starts on the 2nd tick, period=100;
  - locked=1 with the 5th tick;
  - fault stays 0.
- Periods 102, 98, 103, then 100 repeated:
  - 102 and 98 count toward lock;
  - 103 resets good_cnt;
  - locked rises at the 4th good period after the 103.
- Locked, then clk_div_in held low:
  - 200 cycles after the last tick (cnt reaches 199), locked=0 and fault=1;
  - clear_fault pulse -> fault=0, state IDLE;
  - the next two rises give one period_valid.
- Locked, then one period of 90:
  - period=90, period_valid=1, locked=0, fault=1 in the same cycle;
  - fault persists through later good periods until clear_fault.
- rst asserted for 1 cycle while locked, mid-period:
  - all outputs are 0 after the next edge;
  - reacquisition gives locked at the 5th subsequent tick.
- In FAULT, clear_fault coincident with the cycle that rise is high:
  - no period_valid;
  - state IDLE;
  - the following rise enters ACQUIRE without a measurement.
